// File: rtl/ysyx_24090012_axi_arb_pkg.sv
// Shared definitions for the IFU/LSU AXI read arbiter: state encoding, grant
// encoding and the AXI size/burst constants used by the requesters.
package ysyx_24090012_axi_arb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   typedef enum logic [1:0] {
      StIdle = ST_IDLE,
      StAddr = ST_ADDR,
      StData = ST_DATA
   } state_e;

   localparam logic GNT_IFU = 1'b0;
   localparam logic GNT_LSU = 1'b1;

   localparam logic [2:0] SIZE_4B    = 3'b010;
   localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/ysyx_24090012_axi_arb_if.sv
// AXI read-only channel bundle (AR + R). The master modport issues addresses
// and accepts data; the slave modport is the responding side.
interface ysyx_24090012_axi_arb_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic          arvalid;
   logic          arready;
   logic [AW-1:0] araddr;
   logic [3:0]    arid;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;

   logic          rvalid;
   logic          rready;
   logic [DW-1:0] rdata;
   logic [3:0]    rid;
   logic          rlast;
   logic [1:0]    rresp;

   modport master (
      output arvalid, araddr, arid, arlen, arsize, arburst, rready,
      input  arready, rvalid, rdata, rid, rlast, rresp
   );

   modport slave (
      input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
      output arready, rvalid, rdata, rid, rlast, rresp
   );
endinterface

// File: rtl/ysyx_24090012_arb_sel.sv
// Grant selection between IFU and LSU read requests.
// Build option: YSYX_24090012_ARB_RR_EN selects round-robin on simultaneous
// requests; otherwise LSU has fixed priority.
module ysyx_24090012_arb_sel
   import ysyx_24090012_axi_arb_pkg::*;
(
   input  logic ifu_req,
   input  logic lsu_req,
`ifdef YSYX_24090012_ARB_RR_EN
   input  logic last_served,
`endif
   output logic grant
);

   // Pick the winner from the requests seen this cycle.
   always_comb begin
      grant = GNT_IFU;
      if (ifu_req && lsu_req) begin
`ifdef YSYX_24090012_ARB_RR_EN
         grant = (last_served == GNT_LSU) ? GNT_IFU : GNT_LSU;
`else
         grant = GNT_LSU;
`endif
      end else if (lsu_req) begin
         grant = GNT_LSU;
      end
   end

endmodule

// File: rtl/ysyx_24090012_axi_arb.sv
// Two-requester (IFU, LSU) AXI read arbiter onto one shared master port.
// One transaction in flight; grant is decided in IDLE and held through ADDR
// and DATA until the last R beat. Reset gates every output immediately.
// Build option: YSYX_24090012_ARB_RR_EN enables round-robin arbitration.
module ysyx_24090012_axi_arb
   import ysyx_24090012_axi_arb_pkg::*;
#(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   ysyx_24090012_axi_arb_if.slave  ifu,
   ysyx_24090012_axi_arb_if.slave  lsu,
   ysyx_24090012_axi_arb_if.master io_master
);

   state_e        state_q;
   logic          grant_q;
   logic          grant_d;
   logic          in_addr;
   logic          in_data;
   logic          ifu_fwd;
   logic          lsu_fwd;
   logic [AW-1:0] sel_araddr;
   logic [DW-1:0] fwd_rdata;
`ifdef YSYX_24090012_ARB_RR_EN
   logic          last_q;
`endif

   ysyx_24090012_arb_sel u_sel (
      .ifu_req     (ifu.arvalid),
      .lsu_req     (lsu.arvalid),
`ifdef YSYX_24090012_ARB_RR_EN
      .last_served (last_q),
`endif
      .grant       (grant_d)
   );

   // Transaction sequencing: latch grant in IDLE, wait for AR then last R beat.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         grant_q <= GNT_IFU;
`ifdef YSYX_24090012_ARB_RR_EN
         last_q  <= GNT_LSU;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (ifu.arvalid || lsu.arvalid) begin
                  grant_q <= grant_d;
`ifdef YSYX_24090012_ARB_RR_EN
                  last_q  <= grant_d;
`endif
                  state_q <= StAddr;
               end
            end
            StAddr: begin
               if (io_master.arvalid && io_master.arready) begin
                  state_q <= StData;
               end
            end
            StData: begin
               if (io_master.rvalid && io_master.rready && io_master.rlast) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Phase qualifiers; reset kills forwarding in the same cycle it is raised.
   always_comb begin
      in_addr = !reset && (state_q == StAddr);
      in_data = !reset && (state_q == StData);
      ifu_fwd = in_data && (grant_q == GNT_IFU);
      lsu_fwd = in_data && (grant_q == GNT_LSU);
   end

   // AR path: mirror the granted requester onto the shared channel during ADDR.
   always_comb begin
      sel_araddr          = (grant_q == GNT_LSU) ? lsu.araddr : ifu.araddr;
      io_master.arvalid   = 1'b0;
      io_master.araddr    = '0;
      io_master.arid      = '0;
      io_master.arlen     = '0;
      io_master.arsize    = '0;
      io_master.arburst   = '0;
      ifu.arready         = 1'b0;
      lsu.arready         = 1'b0;
      if (in_addr) begin
         io_master.araddr = sel_araddr;
         if (grant_q == GNT_LSU) begin
            io_master.arvalid = lsu.arvalid;
            io_master.arid    = lsu.arid;
            io_master.arlen   = lsu.arlen;
            io_master.arsize  = lsu.arsize;
            io_master.arburst = lsu.arburst;
            lsu.arready       = io_master.arready;
         end else begin
            io_master.arvalid = ifu.arvalid;
            io_master.arid    = ifu.arid;
            io_master.arlen   = ifu.arlen;
            io_master.arsize  = ifu.arsize;
            io_master.arburst = ifu.arburst;
            ifu.arready       = io_master.arready;
         end
      end
   end

   // R path: forward beats (id/resp untouched) only to the granted requester.
   always_comb begin
      fwd_rdata         = io_master.rdata;
      io_master.rready  = (ifu_fwd && ifu.rready) || (lsu_fwd && lsu.rready);
      ifu.rvalid        = ifu_fwd && io_master.rvalid;
      ifu.rdata         = ifu_fwd ? fwd_rdata : '0;
      ifu.rid           = ifu_fwd ? io_master.rid : '0;
      ifu.rlast         = ifu_fwd && io_master.rlast;
      ifu.rresp         = ifu_fwd ? io_master.rresp : '0;
      lsu.rvalid        = lsu_fwd && io_master.rvalid;
      lsu.rdata         = lsu_fwd ? fwd_rdata : '0;
      lsu.rid           = lsu_fwd ? io_master.rid : '0;
      lsu.rlast         = lsu_fwd && io_master.rlast;
      lsu.rresp         = lsu_fwd ? io_master.rresp : '0;
   end

endmodule
